cdma_code_acquisition: RTL and testbench

- PN code acquisition and tracking stage that sits directly upstream of cdma_receiver.
- Takes the raw combined signed BPSK chip stream and searches chip phase by serial sliding correlation against the local user code.
- Declares lock, then forwards aligned samples together with an epoch strobe, so the receiver's correlation period starts on the true code boundary instead of relying on a shared reset.

---
 rtl/cdma_code_acquisition_if.sv | 33 +++
 rtl/cdma_code_acquisition.sv | 189 ++++++++++++++++++
 tb/tb_cdma_code_acquisition.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdma_code_acquisition_if.sv
// Chip-stream bus between the front end, the acquisition stage and the receiver.
interface cdma_code_acquisition_if #(
    parameter int unsigned SAMPLE_W = 8
);
    localparam int unsigned CODE_W = 6;
    localparam int unsigned CORR_W = 15;

    logic                       enable;
    logic        [CODE_W-1:0]   user_code;
    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] sample_out;
    logic                       sample_out_valid;
    logic                       chip_out;
    logic                       epoch;
    logic                       locked;
    logic        [CODE_W-1:0]   code_phase;
    logic signed [CORR_W-1:0]   corr_peak;
    logic                       corr_valid;
    logic                       acq_timeout;

    modport master (
        output enable, user_code, sample_in, sample_valid,
        input  sample_out, sample_out_valid, chip_out, epoch, locked,
               code_phase, corr_peak, corr_valid, acq_timeout
    );

    modport slave (
        input  enable, user_code, sample_in, sample_valid,
        output sample_out, sample_out_valid, chip_out, epoch, locked,
               code_phase, corr_peak, corr_valid, acq_timeout
    );
endinterface

// File: rtl/cdma_code_acquisition.sv
// PN code acquisition/tracking: serial sliding correlation, lock detection and
// forwarding of code-aligned samples with an epoch strobe at chip index 0.
module cdma_code_acquisition #(
    parameter int unsigned SAMPLE_W     = 8,
    parameter int unsigned CODE_LEN     = 64,
    parameter int unsigned ACQ_THRESH   = 3200,
    parameter int unsigned TRACK_THRESH = 2400,
    parameter int unsigned LOSS_LIMIT   = 3
) (
    input logic                    clk,
    input logic                    rst,
    cdma_code_acquisition_if.slave bus
);
    localparam int unsigned ACC_W  = 15;
    localparam int unsigned CODE_W = 6;
    localparam int unsigned IDX_W  = $clog2(CODE_LEN);
    localparam int unsigned MISS_W = $clog2(LOSS_LIMIT + 1);
    localparam int unsigned FAIL_W = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_VERIFY,
        S_LOCK
    } state_t;

    state_t                     state_q, state_d;
    logic        [CODE_W-1:0]   code_q;
    logic        [CODE_W-1:0]   lfsr_q;
    logic        [IDX_W-1:0]    idx_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic                       slip_q;
    logic        [MISS_W-1:0]   miss_q;
    logic        [FAIL_W-1:0]   fail_q;

    logic        [CODE_W-1:0]   seed_new, seed_cur;
    logic                       code_chg, take, slip, dwell_end;
    logic signed [SAMPLE_W-1:0] smp;
    logic signed [ACC_W-1:0]    smp_ext, acc_sum;
    logic        [ACC_W-1:0]    acc_mag;
    logic                       acq_pass, trk_hit;
    logic                       fail_evt, lock_evt, loss_evt;

    // Correlator datapath and dwell qualification.
    always_comb begin
        seed_new  = (bus.user_code == '0) ? CODE_W'(1) : bus.user_code;
        seed_cur  = (code_q == '0) ? CODE_W'(1) : code_q;
        code_chg  = (state_q != S_IDLE) && (bus.user_code != code_q);
        take      = bus.sample_valid && !slip_q;
        slip      = bus.sample_valid && slip_q;
        smp       = bus.sample_in;
        smp_ext   = ACC_W'(smp);
        acc_sum   = lfsr_q[0] ? (acc_q + smp_ext) : (acc_q - smp_ext);
        acc_mag   = acc_sum[ACC_W-1] ? ACC_W'(-acc_sum) : ACC_W'(acc_sum);
        dwell_end = take && (idx_q == IDX_W'(CODE_LEN - 1));
        acq_pass  = acc_mag >= ACC_W'(ACQ_THRESH);
        trk_hit   = acc_mag >= ACC_W'(TRACK_THRESH);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next state and dwell-end events; disable, then code change, outrank dwell end.
    always_comb begin
        state_d  = state_q;
        fail_evt = 1'b0;
        lock_evt = 1'b0;
        loss_evt = 1'b0;
        if (!bus.enable) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
            state_d = S_SEARCH;
        end else if (code_chg) begin
            state_d = S_SEARCH;
        end else if (dwell_end) begin
            case (state_q)
                S_SEARCH: begin
                    if (acq_pass) state_d = S_VERIFY;
                    else          fail_evt = 1'b1;
                end
                S_VERIFY: begin
                    if (acq_pass) begin
                        state_d  = S_LOCK;
                        lock_evt = 1'b1;
                    end else begin
                        state_d  = S_SEARCH;
                        fail_evt = 1'b1;
                    end
                end
                S_LOCK: begin
                    if (!trk_hit && (miss_q == MISS_W'(LOSS_LIMIT - 1))) begin
                        state_d  = S_SEARCH;
                        loss_evt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Code generator, accumulator, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_q               <= '0;
            lfsr_q               <= CODE_W'(1);
            idx_q                <= '0;
            acc_q                <= '0;
            slip_q               <= 1'b0;
            miss_q               <= '0;
            fail_q               <= '0;
            bus.sample_out       <= '0;
            bus.sample_out_valid <= 1'b0;
            bus.chip_out         <= 1'b0;
            bus.epoch            <= 1'b0;
            bus.locked           <= 1'b0;
            bus.code_phase       <= '0;
            bus.corr_peak        <= '0;
            bus.corr_valid       <= 1'b0;
            bus.acq_timeout      <= 1'b0;
        end else begin
            bus.corr_valid       <= 1'b0;
            bus.acq_timeout      <= 1'b0;
            bus.sample_out_valid <= 1'b0;
            bus.epoch            <= 1'b0;
            if (!bus.enable || (state_q == S_IDLE) || code_chg) begin
                code_q         <= bus.user_code;
                lfsr_q         <= seed_new;
                idx_q          <= '0;
                acc_q          <= '0;
                slip_q         <= 1'b0;
                miss_q         <= '0;
                fail_q         <= '0;
                bus.locked     <= 1'b0;
                bus.code_phase <= '0;
                if (!bus.enable || (state_q == S_IDLE)) begin
                    bus.sample_out <= '0;
                    bus.chip_out   <= 1'b0;
                    bus.corr_peak  <= '0;
                end
            end else begin
                if (slip) begin
                    slip_q         <= 1'b0;
                    bus.code_phase <= bus.code_phase + CODE_W'(1);
                end
                if (take) begin
                    bus.sample_out       <= bus.sample_in;
                    bus.chip_out         <= lfsr_q[0];
                    bus.sample_out_valid <= 1'b1;
                    bus.epoch            <= bus.locked && (idx_q == '0);
                    if (dwell_end) begin
                        acc_q          <= '0;
                        idx_q          <= '0;
                        lfsr_q         <= seed_cur;
                        bus.corr_peak  <= acc_sum;
                        bus.corr_valid <= 1'b1;
                    end else begin
                        acc_q  <= acc_sum;
                        idx_q  <= idx_q + IDX_W'(1);
                        lfsr_q <= {lfsr_q[CODE_W-2:0], lfsr_q[5] ^ lfsr_q[4]};
                    end
                end
                if (fail_evt) begin
                    slip_q <= 1'b1;
                    if (&fail_q) begin
                        fail_q          <= '0;
                        bus.acq_timeout <= 1'b1;
                    end else begin
                        fail_q <= fail_q + FAIL_W'(1);
                    end
                end
                if (lock_evt) begin
                    bus.locked <= 1'b1;
                    fail_q     <= '0;
                    miss_q     <= '0;
                end
                if (loss_evt) begin
                    bus.locked <= 1'b0;
                    miss_q     <= '0;
                    slip_q     <= 1'b1;
                end else if ((state_q == S_LOCK) && dwell_end) begin
                    miss_q <= trk_hit ? '0 : (miss_q + MISS_W'(1));
                end
            end
        end
    end
endmodule

// File: tb/tb_cdma_code_acquisition.sv
// Directed bench for cdma_code_acquisition: table vectors plus multi-dwell sequences.
module tb_cdma_code_acquisition;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    cdma_code_acquisition_if #(.SAMPLE_W(8)) bus ();

    cdma_code_acquisition #(
        .SAMPLE_W    (8),
        .CODE_LEN    (64),
        .ACQ_THRESH  (3200),
        .TRACK_THRESH(2400),
        .LOSS_LIMIT  (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic              v;
        int                txi;
        logic signed [7:0] s;
        logic              exp_ov;
        logic signed [7:0] exp_so;
        logic              exp_chip;
    } vec_t;

    vec_t vt [10];
    logic chips [64];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tx_k, corr_cnt, last_corr, pass_cnt, fail_cnt, to_cnt, to_at_corr;
    int   epoch_cnt, epoch_err, chip_err, out_cnt, k;

    function automatic void check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endfunction

    task automatic build_code(input logic [5:0] uc);
        logic [5:0] l;
        l = (uc == 6'd0) ? 6'd1 : uc;
        for (int i = 0; i < 64; i++) begin
            chips[i] = l[0];
            l = {l[4:0], l[5] ^ l[4]};
        end
    endtask

    task automatic clr();
        corr_cnt = 0; last_corr = 0; pass_cnt = 0; fail_cnt = 0; to_cnt = 0; to_at_corr = 0;
        epoch_cnt = 0; epoch_err = 0; chip_err = 0; out_cnt = 0;
    endtask

    // Apply one cycle of input, then observe the registered response.
    task automatic step(input logic signed [7:0] s, input logic v, input int txi);
        int a;
        bus.sample_in    = s;
        bus.sample_valid = v;
        @(posedge clk);
        #1;
        if (bus.corr_valid) begin
            corr_cnt++;
            last_corr = int'(bus.corr_peak);
            a = (last_corr < 0) ? -last_corr : last_corr;
            if (a >= 3200) pass_cnt++;
            else           fail_cnt++;
        end
        if (bus.acq_timeout) begin
            to_cnt++;
            to_at_corr = corr_cnt;
        end
        if (bus.epoch) epoch_cnt++;
        if (bus.sample_out_valid) begin
            out_cnt++;
            if (bus.locked) begin
                if (bus.epoch != (txi == 0)) epoch_err++;
                if (bus.chip_out != chips[txi]) chip_err++;
            end
        end
    endtask

    // Transmit n chips of the current code delayed by off chips, scaled by data.
    task automatic send_code(input int n, input int off, input int data, input int gap_pct);
        int txi;
        int s;
        int g;
        for (int i = 0; i < n; i++) begin
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                g = int'($urandom_range(3, 1));
                repeat (g) step(8'sd0, 1'b0, 0);
            end
            txi = (((tx_k - off) % 64) + 64) % 64;
            s   = (chips[txi] ? 100 : -100) * data;
            step(8'(s), 1'b1, txi);
            tx_k++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable       = 1'b1;
        bus.user_code    = 6'd0;
        bus.sample_in    = 8'sd0;
        bus.sample_valid = 1'b0;
        clr();
        tx_k = 0;

        // Reset dominates enable and samples.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(8'sd77, 1'b1, 0);
        check("rst_out_valid", bus.sample_out_valid, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_phase", bus.code_phase, 0);
        check("rst_corr_peak", bus.corr_peak, 0);
        check("rst_corr_valid", bus.corr_valid, 0);
        check("rst_sample_out", bus.sample_out, 0);

        // Idle: samples driven with enable low produce nothing.
        rst        = 1'b1;
        bus.enable = 1'b0;
        clr();
        for (int i = 0; i < 16; i++) step(8'(i * 5 - 40), 1'b1, 0);
        check("idle_out_count", out_cnt + corr_cnt + epoch_cnt, 0);
        check("idle_locked", bus.locked, 0);

        // Zero offset, user 101011: table vectors then the rest of two dwells.
        bus.user_code = 6'b101011;
        build_code(6'b101011);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            vt[i].v        = !(i == 2 || i == 5 || i == 6);
            vt[i].txi      = k;
            vt[i].s        = vt[i].v ? (chips[k] ? 8'sd100 : -8'sd100) : 8'sd0;
            vt[i].exp_ov   = vt[i].v;
            vt[i].exp_so   = vt[i].s;
            vt[i].exp_chip = chips[k];
            if (vt[i].v) k++;
        end
        bus.enable = 1'b1;
        step(8'sd0, 1'b0, 0);
        step(8'sd0, 1'b0, 0);
        clr();
        for (int i = 0; i < 10; i++) begin
            step(vt[i].s, vt[i].v, vt[i].txi);
            check($sformatf("tbl_valid[%0d]", i), bus.sample_out_valid, vt[i].exp_ov);
            if (vt[i].v) begin
                check($sformatf("tbl_sample[%0d]", i), bus.sample_out, vt[i].exp_so);
                check($sformatf("tbl_chip[%0d]", i), bus.chip_out, vt[i].exp_chip);
            end
        end
        tx_k = k;
        send_code(64 - k, 0, 1, 0);
        check("z_dwell1_valid", bus.corr_valid, 1);
        check("z_dwell1_peak", last_corr, 6400);
        check("z_dwell1_locked", bus.locked, 0);
        send_code(63, 0, 1, 0);
        check("z_pre_lock", bus.locked, 0);
        check("z_corr_pulse_cnt", corr_cnt, 1);
        send_code(1, 0, 1, 0);
        check("z_lock", bus.locked, 1);
        check("z_dwell2_peak", last_corr, 6400);
        check("z_phase", bus.code_phase, 0);
        clr();
        send_code(128, 0, 1, 0);
        check("z_epoch_cnt", epoch_cnt, 2);
        check("z_epoch_align", epoch_err, 0);
        check("z_chip_align", chip_err, 0);

        // Data polarity flip keeps lock.
        clr();
        send_code(128, 0, -1, 0);
        check("pol_corr_cnt", corr_cnt, 2);
        check("pol_peak", last_corr, -6400);
        check("pol_locked", bus.locked, 1);
        check("pol_epoch_align", epoch_err + chip_err, 0);

        // Signal loss: three empty dwells drop lock, then a slip.
        clr();
        send_code(64, 0, 0, 0);
        check("loss1_peak", last_corr, 0);
        check("loss1_locked", bus.locked, 1);
        send_code(64, 0, 0, 0);
        check("loss2_locked", bus.locked, 1);
        send_code(64, 0, 0, 0);
        check("loss3_corr_cnt", corr_cnt, 3);
        check("loss3_locked", bus.locked, 0);
        step(8'sd0, 1'b1, 0);
        check("loss_slip_valid", bus.sample_out_valid, 0);
        check("loss_slip_phase", bus.code_phase, 1);

        // Restart through IDLE, acquire a 17-chip offset.
        bus.enable = 1'b0;
        step(8'sd0, 1'b0, 0);
        check("dis_locked", bus.locked, 0);
        check("dis_phase", bus.code_phase, 0);
        bus.enable = 1'b1;
        step(8'sd0, 1'b0, 0);
        clr();
        tx_k = 0;
        send_code(17 * 65 + 127, 17, 1, 0);
        check("off_fail_dwells", fail_cnt, 17);
        check("off_pass_dwells", pass_cnt, 1);
        check("off_pre_lock", bus.locked, 0);
        send_code(1, 17, 1, 0);
        check("off_lock", bus.locked, 1);
        check("off_phase", bus.code_phase, 17);
        check("off_peak", last_corr, 6400);
        clr();
        send_code(128, 17, 1, 0);
        check("off_epoch_cnt", epoch_cnt, 2);
        check("off_align", epoch_err + chip_err, 0);

        // User code change while locked, then reacquire user 2 with gaps.
        bus.user_code = 6'b110101;
        step(8'sd0, 1'b0, 0);
        check("chg_locked", bus.locked, 0);
        check("chg_phase", bus.code_phase, 0);
        build_code(6'b110101);
        clr();
        tx_k = 0;
        send_code(127, 0, 1, 30);
        check("u2_pre_lock", bus.locked, 0);
        send_code(1, 0, 1, 30);
        check("u2_lock", bus.locked, 1);
        check("u2_corr_cnt", corr_cnt, 2);
        check("u2_peak", last_corr, 6400);
        check("u2_phase", bus.code_phase, 0);
        clr();
        send_code(64, 0, 1, 30);
        check("u2_epoch_cnt", epoch_cnt, 1);
        check("u2_align", epoch_err + chip_err, 0);

        // Asynchronous reset mid-dwell clears outputs without a clock edge.
        send_code(20, 0, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_locked", bus.locked, 0);
        check("arst_peak", bus.corr_peak, 0);
        check("arst_out_valid", bus.sample_out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(8'sd0, 1'b0, 0);

        // No signal: 64 failed dwells pulse acq_timeout once, phase wraps.
        clr();
        for (int i = 0; i < 64 * 65 - 1; i++) step(8'sd0, 1'b1, 0);
        check("to_corr_cnt", corr_cnt, 64);
        check("to_pulse_cnt", to_cnt, 1);
        check("to_at_dwell", to_at_corr, 64);
        check("to_phase_pre", bus.code_phase, 63);
        step(8'sd0, 1'b1, 0);
        check("to_phase_wrap", bus.code_phase, 0);
        check("to_slip_valid", bus.sample_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
